// File: rtl/z_stream_packer.sv
// Packs sampled z bits MSB-first into WORD_W-bit words and hands them out over valid/ready.
// A closed word can wait in the shift register (PEND) while the output register is occupied.
module z_stream_packer #(
  parameter int WORD_W    = 8,
  parameter int BIT_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 z_in,
  input  logic                 sample_en,
  input  logic                 flush,
  input  logic                 ovf_clr,
  output logic [WORD_W-1:0]    word_out,
  output logic [BIT_CNT_W-1:0] word_bits,
  output logic                 word_par,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 overflow
);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;
  localparam logic [BIT_CNT_W-1:0] FULL_CNT = BIT_CNT_W'(WORD_W);

  logic [WORD_W-1:0]    sh_reg, sh_next;
  logic [BIT_CNT_W-1:0] cnt_reg, cnt_next;
  logic [0:0]           state_reg, state_next;
  logic [WORD_W-1:0]    word_out_reg, word_out_next;
  logic [BIT_CNT_W-1:0] word_bits_reg, word_bits_next;
  logic                 word_par_reg, word_par_next;
  logic                 word_valid_reg, word_valid_next;
  logic                 overflow_reg, overflow_next;

  logic                 out_free;
  logic [WORD_W-1:0]    fill_sh;
  logic [BIT_CNT_W-1:0] fill_cnt;
  logic                 close_word;
  logic                 load_out;
  logic                 ovf_set;
  logic [WORD_W-1:0]    load_sh;
  logic [BIT_CNT_W-1:0] load_cnt;
  logic [WORD_W-1:0]    aligned_word;

  assign out_free = !word_valid_reg || word_ready;

  // The same-cycle sample is folded in before the close decision, so a flush
  // on the edge of a sample closes a word that already contains that bit.
  assign fill_sh    = sample_en ? {sh_reg[WORD_W-2:0], z_in} : sh_reg;
  assign fill_cnt   = cnt_reg + BIT_CNT_W'(sample_en);
  assign close_word = (state_reg == ST_FILL) &&
                      ((fill_cnt == FULL_CNT) || (flush && (fill_cnt != '0)));

  assign load_sh  = (state_reg == ST_PEND) ? sh_reg  : fill_sh;
  assign load_cnt = (state_reg == ST_PEND) ? cnt_reg : fill_cnt;
  assign load_out = ((state_reg == ST_PEND) || close_word) && out_free;

  // Only the low load_cnt bits of the shift register belong to this word;
  // shifting left discards any stale upper bits and zero-pads the LSBs.
  assign aligned_word = load_sh << (FULL_CNT - load_cnt);

  always_comb begin
    sh_next    = sh_reg;
    cnt_next   = cnt_reg;
    state_next = state_reg;
    ovf_set    = 1'b0;

    case (state_reg)
      ST_FILL: begin
        if (close_word && out_free) begin
          sh_next  = '0;
          cnt_next = '0;
        end else if (close_word) begin
          sh_next    = fill_sh;
          cnt_next   = fill_cnt;
          state_next = ST_PEND;
        end else begin
          sh_next  = fill_sh;
          cnt_next = fill_cnt;
        end
      end
      ST_PEND: begin
        if (out_free) begin
          // Zero-bubble handover: a sample on this edge starts the next word.
          state_next = ST_FILL;
          sh_next    = sample_en ? WORD_W'(z_in) : '0;
          cnt_next   = sample_en ? BIT_CNT_W'(1) : '0;
        end else begin
          ovf_set = sample_en;
        end
      end
      default: begin
        state_next = ST_FILL;
        sh_next    = '0;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    word_out_next   = word_out_reg;
    word_bits_next  = word_bits_reg;
    word_par_next   = word_par_reg;
    word_valid_next = word_valid_reg;

    if (load_out) begin
      word_out_next   = aligned_word;
      word_bits_next  = load_cnt;
      word_par_next   = ^aligned_word;
      word_valid_next = 1'b1;
    end else if (word_valid_reg && word_ready) begin
      word_valid_next = 1'b0;
    end
  end

  always_comb begin
    overflow_next = overflow_reg;
    if (ovf_set) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh_reg         <= '0;
      cnt_reg        <= '0;
      state_reg      <= ST_FILL;
      word_out_reg   <= '0;
      word_bits_reg  <= '0;
      word_par_reg   <= 1'b0;
      word_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      sh_reg         <= sh_next;
      cnt_reg        <= cnt_next;
      state_reg      <= state_next;
      word_out_reg   <= word_out_next;
      word_bits_reg  <= word_bits_next;
      word_par_reg   <= word_par_next;
      word_valid_reg <= word_valid_next;
      overflow_reg   <= overflow_next;
    end
  end

  assign word_out   = word_out_reg;
  assign word_bits  = word_bits_reg;
  assign word_par   = word_par_reg;
  assign word_valid = word_valid_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_z_stream_packer.sv
// Directed table-driven bench for z_stream_packer (WORD_W=8), plus a hand-written
// sequence for PEND handover, same-edge sampling and overflow set-vs-clear priority.
module tb_z_stream_packer;

  logic       clk;
  logic       reset;
  logic       z_in;
  logic       sample_en;
  logic       flush;
  logic       ovf_clr;
  logic [7:0] word_out;
  logic [3:0] word_bits;
  logic       word_par;
  logic       word_valid;
  logic       word_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rst_n;
    logic       z;
    logic       se;
    logic       fl;
    logic       oc;
    logic       rdy;
    logic       ev;
    logic [7:0] ew;
    logic [3:0] eb;
    logic       ep;
    logic       eo;
  } vec_t;

  vec_t vecs[0:199];
  int   nvec = 0;

  z_stream_packer #(.WORD_W(8), .BIT_CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .z_in       (z_in),
    .sample_en  (sample_en),
    .flush      (flush),
    .ovf_clr    (ovf_clr),
    .word_out   (word_out),
    .word_bits  (word_bits),
    .word_par   (word_par),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string nm, logic rst_n, logic z, logic se, logic fl,
                              logic oc, logic rdy, logic ev, logic [7:0] ew,
                              logic [3:0] eb, logic ep, logic eo);
    vec_t v;
    v.name = nm; v.rst_n = rst_n; v.z = z; v.se = se; v.fl = fl; v.oc = oc;
    v.rdy = rdy; v.ev = ev; v.ew = ew; v.eb = eb; v.ep = ep; v.eo = eo;
    return v;
  endfunction

  task automatic add(string nm, logic rst_n, logic z, logic se, logic fl, logic oc,
                     logic rdy, logic ev, logic [7:0] ew, logic [3:0] eb, logic ep,
                     logic eo);
    vecs[nvec] = mk(nm, rst_n, z, se, fl, oc, rdy, ev, ew, eb, ep, eo);
    nvec++;
  endtask

  // Eight consecutive samples of w (MSB first); the first seven rows expect the
  // "mid" outputs, the closing row expects the "end" outputs.
  task automatic add_word(string nm, logic [7:0] w, logic rdy,
                          logic mev, logic [7:0] mew, logic [3:0] meb, logic mep,
                          logic eev, logic [7:0] eew, logic [3:0] eeb, logic eep,
                          logic eo);
    for (int i = 7; i >= 1; i--)
      add(nm, 1, w[i], 1, 0, 0, rdy, mev, mew, meb, mep, eo);
    add(nm, 1, w[0], 1, 0, 0, rdy, eev, eew, eeb, eep, eo);
  endtask

  task automatic chk(string nm, string field, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, field, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    reset      = v.rst_n;
    z_in       = v.z;
    sample_en  = v.se;
    flush      = v.fl;
    ovf_clr    = v.oc;
    word_ready = v.rdy;
    @(posedge clk);
    #1;
    $display("%-5s rst_n=%0b z=%0b se=%0b fl=%0b oc=%0b rdy=%0b -> valid=%0b word=%02h bits=%0d par=%0b ovf=%0b",
             v.name, v.rst_n, v.z, v.se, v.fl, v.oc, v.rdy,
             word_valid, word_out, word_bits, word_par, overflow);
    chk(v.name, "word_valid", 32'(word_valid), 32'(v.ev));
    chk(v.name, "overflow", 32'(overflow), 32'(v.eo));
    if (v.ev || !v.rst_n) begin
      chk(v.name, "word_out", 32'(word_out), 32'(v.ew));
      chk(v.name, "word_bits", 32'(word_bits), 32'(v.eb));
      chk(v.name, "word_par", 32'(word_par), 32'(v.ep));
    end
  endtask

  initial begin
    logic [7:0] hw;

    reset = 1'b0; z_in = 1'b0; sample_en = 1'b0; flush = 1'b0;
    ovf_clr = 1'b0; word_ready = 1'b0;

    // ---- table ----
    add("RST", 0, 0, 0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("RST", 0, 1, 1, 1, 1, 1, 0, 8'h00, 4'd0, 0, 0);
    // T1: full word, parity even
    add_word("T1", 8'hB2, 1, 0, 8'h00, 4'd0, 0, 1, 8'hB2, 4'd8, 0, 0);
    add("T1i", 1, 0, 0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    // T2: 3 bits then flush; flush with cnt=0 produces nothing
    add("T2", 1, 1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T2", 1, 1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T2", 1, 0, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T2f", 1, 0, 0, 1, 0, 1, 1, 8'hC0, 4'd3, 0, 0);
    add("T2e", 1, 0, 0, 1, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T2e", 1, 0, 0, 1, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    // T3: flush on the same edge as the 5th sample
    add("T3", 1, 1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T3", 1, 0, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T3", 1, 0, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T3", 1, 0, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T3f", 1, 1, 1, 1, 0, 1, 1, 8'h88, 4'd5, 0, 0);
    add("T3i", 1, 0, 0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    // single-bit word, odd parity
    add("TP", 1, 1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("TPf", 1, 0, 0, 1, 0, 1, 1, 8'h80, 4'd1, 1, 0);
    add("TPi", 1, 0, 0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    // T4: consumer stalled, skid word, overflow on 17th bit
    add_word("T4a", 8'hFF, 0, 0, 8'h00, 4'd0, 0, 1, 8'hFF, 4'd8, 0, 0);
    add_word("T4b", 8'h0F, 0, 1, 8'hFF, 4'd8, 0, 1, 8'hFF, 4'd8, 0, 0);
    add("T4o", 1, 1, 1, 0, 0, 0, 1, 8'hFF, 4'd8, 0, 1);
    add("T4d", 1, 0, 0, 0, 0, 1, 1, 8'h0F, 4'd8, 0, 1);
    add("T4c", 1, 0, 0, 0, 1, 1, 0, 8'h00, 4'd0, 0, 0);
    // T5: 24 continuous bits, each word valid for one cycle
    add_word("T5a", 8'h3C, 1, 0, 8'h00, 4'd0, 0, 1, 8'h3C, 4'd8, 0, 0);
    add_word("T5b", 8'h07, 1, 0, 8'h00, 4'd0, 0, 1, 8'h07, 4'd8, 1, 0);
    add_word("T5c", 8'h81, 1, 0, 8'h00, 4'd0, 0, 1, 8'h81, 4'd8, 0, 0);
    add("T5i", 1, 0, 0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    // T6: reset mid-word discards partial bits
    add("T6", 1, 1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T6", 1, 1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T6", 1, 1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T6", 1, 1, 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add("T6r", 0, 1, 1, 1, 0, 1, 0, 8'h00, 4'd0, 0, 0);
    add_word("T6w", 8'h5A, 1, 0, 8'h00, 4'd0, 0, 1, 8'h5A, 4'd8, 0, 0);
    add("T6i", 1, 0, 0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0);

    for (int i = 0; i < nvec; i++)
      apply(vecs[i]);

    // ---- hand sequence: PEND handover with same-edge sample, set beats clear ----
    hw = 8'hAA;
    for (int i = 7; i >= 1; i--)
      apply(mk("HA", 1, hw[i], 1, 0, 0, 0, 0, 8'h00, 4'd0, 0, 0));
    apply(mk("HA", 1, hw[0], 1, 0, 0, 0, 1, 8'hAA, 4'd8, 0, 0));
    hw = 8'h55;
    for (int i = 7; i >= 0; i--)
      apply(mk("HB", 1, hw[i], 1, 0, 0, 0, 1, 8'hAA, 4'd8, 0, 0));
    apply(mk("Hset", 1, 0, 1, 0, 1, 0, 1, 8'hAA, 4'd8, 0, 1));
    apply(mk("Hho", 1, 1, 1, 1, 0, 1, 1, 8'h55, 4'd8, 0, 1));
    apply(mk("Hclr", 1, 0, 1, 0, 1, 1, 0, 8'h00, 4'd0, 0, 0));
    hw = 8'h01;
    for (int i = 5; i >= 1; i--)
      apply(mk("HC", 1, hw[i], 1, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0));
    apply(mk("HC", 1, hw[0], 1, 0, 0, 1, 1, 8'h81, 4'd8, 0, 0));
    apply(mk("Hi", 1, 0, 0, 0, 0, 1, 0, 8'h00, 4'd0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
